// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC custom-instruction issuer.
package cordic_pkg;

    localparam int THETA_W_DEF  = 23;
    localparam int RESULT_W_DEF = 22;

    // 1.0 in the signed 1.1.21 angle format
    localparam logic [THETA_W_DEF-1:0] THETA_ONE = 23'h200000;

    localparam int FLAG_W       = 2;
    localparam int FLAG_RANGE   = 0;
    localparam int FLAG_TIMEOUT = 1;

    localparam logic [FLAG_W-1:0] FLAG_RANGE_MASK   = FLAG_W'(1) << FLAG_RANGE;
    localparam logic [FLAG_W-1:0] FLAG_TIMEOUT_MASK = FLAG_W'(1) << FLAG_TIMEOUT;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PUSH
    } state_t;

    // One output FIFO entry: flags sit above the result
    typedef struct packed {
        logic [FLAG_W-1:0]       flags;
        logic [RESULT_W_DEF-1:0] result;
    } entry_t;

endpackage

// File: rtl/cordic_result_fifo.sv
// Small circular result buffer; DEPTH must be a power of two so pointers wrap naturally.
module cordic_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Storage array; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/cordic_ci_issuer.sv
// Initiator for the CORDIC multicycle custom instruction: range-checks angles,
// drives the start/done handshake with a timeout, and queues flagged results.
import cordic_pkg::*;

module cordic_ci_issuer #(
    parameter int THETA_W   = THETA_W_DEF,
    parameter int RESULT_W  = RESULT_W_DEF,
    parameter int TIMEOUT   = 64,
    parameter int OUT_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [THETA_W-1:0]  in_theta,
    output logic                ci_clk_en,
    output logic                ci_start,
    output logic [THETA_W-1:0]  ci_theta,
    input  logic                ci_done,
    input  logic [RESULT_W-1:0] ci_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result,
    output logic [FLAG_W-1:0]   out_flags,
    output logic                busy
);

    localparam int ENTRY_W = FLAG_W + RESULT_W;
    localparam int CNT_W   = $clog2(TIMEOUT);
    localparam int OCC_W   = $clog2(OUT_DEPTH + 1);

    // +1.0 and -1.0 in the signed angle format; anything strictly outside is rejected
    localparam logic signed [THETA_W-1:0] LP_POS_ONE = THETA_W'(1) << (THETA_W - 2);
    localparam logic signed [THETA_W-1:0] LP_NEG_ONE = -LP_POS_ONE;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_ci_start;
    logic                r_ci_clk_en;
    logic [THETA_W-1:0]  r_ci_theta;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [FLAG_W-1:0]   r_flags;
    logic [RESULT_W-1:0] r_result;

    logic                w_accept;
    logic                w_out_of_range;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_empty;
    logic                w_out_nonempty;
    logic [OCC_W-1:0]    w_occupancy;
    logic [OCC_W-1:0]    w_occupancy_next;
    logic [ENTRY_W-1:0]  w_head;

    assign w_accept       = in_valid && r_in_ready && (r_state == IDLE);
    assign w_out_of_range = ($signed(in_theta) > LP_POS_ONE) || ($signed(in_theta) < LP_NEG_ONE);
    assign w_push         = (r_state == PUSH);
    assign w_out_nonempty = !w_fifo_empty;
    assign w_pop          = out_ready && w_out_nonempty;

    // Occupancy after this cycle's push/pop decides whether a new request still has a slot
    assign w_occupancy_next = w_occupancy + OCC_W'(w_push) - OCC_W'(w_pop);

    // Request sequencer: accept, issue, wait for done or timeout, push the flagged result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_ci_start  <= 1'b0;
            r_ci_clk_en <= 1'b0;
            r_ci_theta  <= '0;
            r_wait_cnt  <= '0;
            r_flags     <= '0;
            r_result    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_out_of_range) begin
                            r_flags  <= FLAG_RANGE_MASK;
                            r_result <= '0;
                            r_state  <= PUSH;
                        end else begin
                            r_ci_theta  <= in_theta;
                            r_ci_start  <= 1'b1;
                            r_ci_clk_en <= 1'b1;
                            r_state     <= ISSUE;
                        end
                    end else begin
                        r_in_ready <= (w_occupancy_next < OCC_W'(OUT_DEPTH));
                    end
                end
                ISSUE: begin
                    r_ci_start <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (ci_done) begin
                        r_result    <= ci_result;
                        r_flags     <= '0;
                        r_ci_clk_en <= 1'b0;
                        r_state     <= PUSH;
                    end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_result    <= '0;
                        r_flags     <= FLAG_TIMEOUT_MASK;
                        r_ci_clk_en <= 1'b0;
                        r_state     <= PUSH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                PUSH: begin
                    r_in_ready <= (w_occupancy_next < OCC_W'(OUT_DEPTH));
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    cordic_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_flags, r_result}),
        .o_head  (w_head),
        .o_count (w_occupancy),
        .o_empty (w_fifo_empty)
    );

    assign in_ready   = r_in_ready;
    assign ci_start   = r_ci_start;
    assign ci_clk_en  = r_ci_clk_en;
    assign ci_theta   = r_ci_theta;
    assign busy       = (r_state != IDLE);
    assign out_valid  = w_out_nonempty;
    assign out_result = w_out_nonempty ? w_head[RESULT_W-1:0] : '0;
    assign out_flags  = w_out_nonempty ? w_head[ENTRY_W-1:RESULT_W] : '0;

endmodule

// File: tb/tb_cordic_ci_issuer.sv
// Self-checking bench for cordic_ci_issuer with a responder and an in-order result model.
module tb_cordic_ci_issuer;
    import cordic_pkg::*;

    localparam int TW    = 23;
    localparam int RW    = 22;
    localparam int TO    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_theta;
    logic          ci_clk_en;
    logic          ci_start;
    logic [TW-1:0] ci_theta;
    logic          ci_done;
    logic [RW-1:0] ci_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_result;
    logic [1:0]    out_flags;
    logic          busy;

    int     vectors = 0;
    int     miscompares = 0;
    entry_t expQ[$];

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    cordic_ci_issuer #(
        .THETA_W   (TW),
        .RESULT_W  (RW),
        .TIMEOUT   (TO),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_theta   (in_theta),
        .ci_clk_en  (ci_clk_en),
        .ci_start   (ci_start),
        .ci_theta   (ci_theta),
        .ci_done    (ci_done),
        .ci_result  (ci_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .busy       (busy)
    );

    // Single comparison point: counts every vector and reports any miscompare
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Angle magnitude above 1.0 (2^21) is a range error
    function automatic bit outOfRange(input logic [TW-1:0] th);
        int v;
        v = int'($signed(th));
        return (v > (1 << 21)) || (v < -(1 << 21));
    endfunction

    // Expected entry: done counts only in the TIMEOUT-cycle window after the start cycle
    function automatic entry_t expectEntry(input logic [TW-1:0] th, input int doneAt, input logic [RW-1:0] res);
        entry_t e;
        if (outOfRange(th)) begin
            e.flags  = 2'b01;
            e.result = '0;
        end else if (doneAt >= 1 && doneAt <= TO) begin
            e.flags  = 2'b00;
            e.result = res;
        end else begin
            e.flags  = 2'b10;
            e.result = '0;
        end
        return e;
    endfunction

    // Cycles after accept until the issuer is idle again with the entry queued
    function automatic int expectIdle(input logic [TW-1:0] th, input int doneAt);
        if (outOfRange(th)) return 1;
        if (doneAt >= 1 && doneAt <= TO) return doneAt + 2;
        return TO + 2;
    endfunction

    // One request: handshake in, act as core responder, check timing and record the expected entry.
    // Cycle 0 is the first cycle after accept; done driven in cycle a is seen at the edge ending it.
    task automatic applyStimulus(input string tag, input logic [TW-1:0] theta, input int doneAt,
                                 input logic [RW-1:0] res, input bit earlyDone, input logic [RW-1:0] earlyRes);
        int guard   = 0;
        int starts  = 0;
        int startAt = -1;
        int idleAt  = -1;
        bit thetaOk = 1'b1;
        bit oor;
        oor = outOfRange(theta);
        in_valid = 1'b1;
        in_theta = theta;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_accept"}, 64'(in_ready), 64'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_theta = TW'($urandom);
        for (int a = 0; a < 300; a++) begin
            if (!busy) begin
                idleAt = a;
                break;
            end
            if (ci_start) begin
                starts++;
                startAt = a;
            end
            if (ci_clk_en && ci_theta !== theta) thetaOk = 1'b0;
            ci_done   = (a == doneAt) || (earlyDone && a == 0);
            ci_result = (earlyDone && a == 0) ? earlyRes : ((a == doneAt) ? res : RW'($urandom));
            @(negedge clk);
        end
        ci_done = 1'b0;
        checkOutput({tag, "_idle_cycle"}, 64'(idleAt), 64'(expectIdle(theta, doneAt)));
        checkOutput({tag, "_starts"}, 64'(starts), oor ? 64'd0 : 64'd1);
        if (!oor) checkOutput({tag, "_start_cycle"}, 64'(startAt), 64'd0);
        checkOutput({tag, "_theta_held"}, 64'(thetaOk), 64'd1);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        expQ.push_back(expectEntry(theta, doneAt, res));
    endtask

    // Pop every modelled entry in order, then require the FIFO to be empty
    task automatic drainFifo(input string tag);
        entry_t e;
        int n = 0;
        out_ready = 1'b1;
        while (expQ.size() > 0 && n < 20) begin
            e = expQ.pop_front();
            checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, "_flags"}, 64'(out_flags), 64'(e.flags));
            checkOutput({tag, "_result"}, 64'(out_result), 64'(e.result));
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checkOutput({tag, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_ci_start"}, 64'(ci_start), 64'd0);
        checkOutput({tag, "_ci_clk_en"}, 64'(ci_clk_en), 64'd0);
        checkOutput({tag, "_ci_theta"}, 64'(ci_theta), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_out_result"}, 64'(out_result), 64'd0);
        checkOutput({tag, "_out_flags"}, 64'(out_flags), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence followed by randomized requests
    initial begin
        logic [TW-1:0] th;
        logic [TW-1:0] th5;
        logic [RW-1:0] res5;
        int            sel;

        in_valid  = 1'b0;
        in_theta  = '0;
        ci_done   = 1'b0;
        ci_result = '0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkResetValues("rst");
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] basic request with done 5 cycles after start");
        applyStimulus("basic", 23'h000000, 5, 22'h1FFFFF, 1'b0, '0);
        drainFifo("basic_drain");

        $display("[TB] out-of-range request");
        applyStimulus("range", 23'h200001, -1, 22'h0, 1'b0, '0);
        drainFifo("range_drain");

        $display("[TB] timeout then stray done");
        applyStimulus("tmo", 23'h012345, -1, 22'h3, 1'b0, '0);
        ci_done   = 1'b1;
        ci_result = 22'h2BCDEF;
        @(negedge clk);
        ci_done = 1'b0;
        repeat (3) @(negedge clk);
        drainFifo("tmo_drain");

        $display("[TB] range boundaries");
        applyStimulus("b_pos_one", 23'h200000, 1, 22'h0ABCDE, 1'b0, '0);
        applyStimulus("b_neg_one", 23'h600000, 3, 22'h3FFFFF, 1'b0, '0);
        applyStimulus("b_most_neg", 23'h400000, 2, 22'h111111, 1'b0, '0);
        applyStimulus("b_below_neg", 23'h5FFFFF, 2, 22'h222222, 1'b0, '0);
        drainFifo("b_drain");

        $display("[TB] fifo full back-pressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus("fill", TW'($urandom_range(0, 32'h1FFFFF)), $urandom_range(1, 8), RW'($urandom), 1'b0, '0);
        end
        th5  = 23'h0F0F0F;
        res5 = 22'h345678;
        in_valid = 1'b1;
        in_theta = th5;
        for (int i = 0; i < 6; i++) begin
            checkOutput("full_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        checkOutput("full_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;
        drainFifo("full_drain");
        applyStimulus("fifth", th5, 2, res5, 1'b0, '0);
        drainFifo("fifth_drain");

        $display("[TB] done in ISSUE cycle and at last wait cycle");
        applyStimulus("early", 23'h100000, TO, 22'h2AAAAA, 1'b1, 22'h155555);
        drainFifo("early_drain");
        applyStimulus("late", 23'h080000, TO + 1, 22'h3C3C3C, 1'b0, '0);
        drainFifo("late_drain");

        $display("[TB] randomized requests");
        for (int i = 0; i < 8; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: th = TW'($urandom);
                1: begin
                    th = TW'($urandom_range(0, 32'h200000));
                    if ($urandom_range(0, 1) == 1) th = -th;
                end
                2: th = 23'h200000 + TW'($urandom_range(0, 2)) - 23'd1;
                default: th = 23'h600000 + TW'($urandom_range(0, 2)) - 23'd1;
            endcase
            applyStimulus("rand", th, $urandom_range(1, 70), RW'($urandom), 1'($urandom_range(0, 1)), RW'($urandom));
            if (expQ.size() >= 2) drainFifo("rand_drain");
        end
        drainFifo("rand_final");

        $display("[TB] reset during WAIT");
        in_valid = 1'b1;
        in_theta = 23'h001000;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_busy", 64'(busy), 64'd1);
        checkOutput("mid_clk_en", 64'(ci_clk_en), 64'd1);
        reset = 1'b0;
        #1;
        checkResetValues("mid_rst");
        @(negedge clk);
        ci_done   = 1'b1;
        ci_result = 22'h0FACE0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ci_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
